fpnew_opgroup_ordered_collector: RTL

// - Dispatch/collect stage for N parallel operation slices (per-format or per-lane) in one opgroup.
// - Routes each accepted operation to a selected channel and records the channel index in an
//   in-flight ID FIFO.
// - Retires results strictly in issue order; this replaces round-robin output arbitration,

---
 rtl/fpnew_opgroup_ordered_collector.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fpnew_opgroup_ordered_collector.sv
// fpnew_opgroup_ordered_collector
//   Dispatch/collect stage for NumChan parallel slices of one opgroup. Each
//   accepted operation is steered to its channel and the channel index is
//   queued in an in-flight ID FIFO; results retire strictly in issue order
//   by only granting chan_out_ready_o to the channel at the FIFO head.
//   Zero added latency: all handshake outputs are combinational.
//
//   Ports
//     clk_i, rst_i        clock, synchronous active-high reset
//     flush_i             drop all in-flight bookkeeping (synchronous)
//     in_valid_i/ready_o  opgroup input handshake, in_chan_i selects channel
//     chan_valid_o/ready_i  per-channel issue handshake
//     chan_data_i/out_valid_i/out_ready_o  per-channel result handshake
//     out_data_o/valid_o/ready_i  retired result stream
//     inflight_o, busy_o  in-flight count and non-empty flag
//
//   Optional: define FPNEW_ORDERED_COLLECTOR_PERF_EN to add hol_stall_o, a
//   saturating count of head-of-line stall cycles (cleared by rst_i only).
module fpnew_opgroup_ordered_collector #(
  parameter int unsigned NumChan   = 4,
  parameter int unsigned DataWidth = 38,
  parameter int unsigned Depth     = 8,
  localparam int unsigned ChanIdxW = $clog2(NumChan),
  localparam int unsigned CntW     = $clog2(Depth + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [ChanIdxW-1:0]            in_chan_i,
  output logic [NumChan-1:0]             chan_valid_o,
  input  logic [NumChan-1:0]             chan_ready_i,
  input  logic [NumChan*DataWidth-1:0]   chan_data_i,
  input  logic [NumChan-1:0]             chan_out_valid_i,
  output logic [NumChan-1:0]             chan_out_ready_o,
  output logic [DataWidth-1:0]           out_data_o,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [CntW-1:0]                inflight_o,
  output logic                           busy_o
`ifdef FPNEW_ORDERED_COLLECTOR_PERF_EN
  ,
  output logic [31:0]                    hol_stall_o
`endif
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [ChanIdxW-1:0] fifo_q [Depth];
  logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]     count_q;

  logic                kill;
  logic                full;
  logic                not_empty;
  logic                chan_ok;
  logic                issue_ok;
  logic                push;
  logic                pop;
  logic [ChanIdxW-1:0] head;
  logic [NumChan-1:0]  chan_sel;
  logic [NumChan-1:0]  head_sel;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Out-of-range check only exists when NumChan is not a power of two
  if (NumChan == (1 << ChanIdxW)) begin : g_chan_full_range
    assign chan_ok = 1'b1;
  end else begin : g_chan_partial_range
    assign chan_ok = ({1'b0, in_chan_i} < (ChanIdxW + 1)'(NumChan));
  end

  // Reset and flush both squash every handshake in the cycle they are seen
  assign kill      = flush_i | rst_i;
  assign full      = (count_q == CntW'(Depth));
  assign not_empty = (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  // One-hot decode of the requested channel and the head channel
  always_comb begin
    chan_sel = '0;
    head_sel = '0;
    for (int c = 0; c < NumChan; c++) begin
      chan_sel[c] = (in_chan_i == ChanIdxW'(c));
      head_sel[c] = (head == ChanIdxW'(c));
    end
  end

  // Issue side
  assign issue_ok     = !full && !kill && chan_ok;
  assign in_ready_o   = issue_ok && |(chan_ready_i & chan_sel);
  assign chan_valid_o = (in_valid_i && issue_ok) ? chan_sel : '0;
  assign push         = in_valid_i && in_ready_o;

  // Retire side: only the head channel may hand over its result
  assign out_valid_o      = not_empty && !kill && |(chan_out_valid_i & head_sel);
  assign chan_out_ready_o = (out_ready_i && not_empty && !kill) ? head_sel : '0;
  assign pop              = out_valid_o && out_ready_i;

  always_comb begin
    out_data_o = '0;
    for (int c = 0; c < NumChan; c++) begin
      if (head_sel[c]) out_data_o = chan_data_i[c*DataWidth +: DataWidth];
    end
  end

  assign inflight_o = count_q;
  assign busy_o     = not_empty;

  // Channel-ID storage; contents are only meaningful below count_q
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= in_chan_i;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (kill) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef FPNEW_ORDERED_COLLECTOR_PERF_EN
  logic hol_cond;

  // Head result missing while some younger result is already waiting
  assign hol_cond = not_empty && !(|(chan_out_valid_i & head_sel))
                    && |(chan_out_valid_i & ~head_sel);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hol_stall_o <= '0;
    end else if (hol_cond && (hol_stall_o != 32'hFFFF_FFFF)) begin
      hol_stall_o <= hol_stall_o + 32'd1;
    end
  end
`endif

endmodule
